// File: rtl/dram_pkg.sv
// dram_pkg: shared constants and FSM state encoding for the DRAM responder model
package dram_pkg;
    localparam int DEF_AW      = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_CAS_LAT = 2;
    localparam int REF_W       = 16;
    localparam int LAT_W       = 3;
    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t ROW_OPEN = 2'd1;
    localparam state_t COL_WAIT = 2'd2;
    localparam state_t CBR      = 2'd3;
endpackage

// File: rtl/dram_array.sv
// dram_array: synchronous-write, registered-read storage; only the read register is reset
module dram_array #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    // array contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // read register only updates when a read completes, so it holds between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/dram_responder.sv
// dram_responder: RAS/CAS-driven DRAM device model with page mode, CBR refresh count and protocol error flag
module dram_responder
    import dram_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int CAS_LAT = DEF_CAS_LAT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ras_n,
    input  logic             cas_n,
    input  logic             we_n,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    output logic [REF_W-1:0] refresh_cnt,
    output logic             err
);
    logic             ras_q, cas_q;
    logic             ras_fall, ras_rise, cas_fall;
    state_t           state, state_d;
    logic [AW-1:0]    row, row_d, col, col_d;
    logic [LAT_W-1:0] cnt, cnt_d;
    logic             valid_d, err_d, wr, rd;
    logic [REF_W-1:0] ref_d;
    logic [2*AW-1:0]  rd_addr;

    assign ras_fall = !ras_n && ras_q;
    assign ras_rise = ras_n && !ras_q;
    assign cas_fall = !cas_n && cas_q;

    // previous strobe levels for edge detection; idle level is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_q <= 1'b1;
            cas_q <= 1'b1;
        end else begin
            ras_q <= ras_n;
            cas_q <= cas_n;
        end
    end

    // protocol FSM: the read is issued to the array one cycle early so its registered output lands at CAS_LAT
    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        cnt_d   = cnt;
        wr      = 1'b0;
        rd      = 1'b0;
        rd_addr = {row, col};
        valid_d = 1'b0;
        ref_d   = refresh_cnt;
        err_d   = err;
        case (state)
            IDLE: begin
                if (ras_fall) begin
                    if (!cas_n && !cas_q) begin
                        state_d = CBR;
                    end else begin
                        row_d   = addr;
                        state_d = ROW_OPEN;
                        err_d   = err | cas_fall;
                    end
                end
            end
            ROW_OPEN: begin
                if (ras_rise) begin
                    state_d = IDLE;
                end else if (cas_fall) begin
                    col_d = addr;
                    if (!we_n) begin
                        wr = 1'b1;
                    end else if (CAS_LAT == 1) begin
                        rd      = 1'b1;
                        rd_addr = {row, addr};
                        valid_d = 1'b1;
                    end else begin
                        cnt_d   = 1;
                        state_d = COL_WAIT;
                    end
                end
            end
            COL_WAIT: begin
                if (ras_rise) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    err_d = err | cas_fall;
                    if (cnt == LAT_W'(CAS_LAT - 1)) begin
                        rd      = 1'b1;
                        valid_d = 1'b1;
                        state_d = ROW_OPEN;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (ras_rise) begin
                    ref_d   = refresh_cnt + 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // state and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            cnt         <= '0;
            dout_valid  <= 1'b0;
            refresh_cnt <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            row         <= row_d;
            col         <= col_d;
            cnt         <= cnt_d;
            dout_valid  <= valid_d;
            refresh_cnt <= ref_d;
            err         <= err_d;
        end
    end

    dram_array #(.AW(2 * AW), .DW(DW)) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr),
        .waddr   ({row, addr}),
        .wdata   (din),
        .re      (rd),
        .raddr   (rd_addr),
        .rdata   (dout)
    );
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: directed RAS/CAS sequences with hand-computed expectations
module tb_dram_responder;
    localparam int LAT = 2;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [3:0]  addr = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [15:0] refresh_cnt;
    logic        err;
    int          checks = 0, errors = 0, pulses = 0;

    dram_responder #(.AW(4), .DW(8), .CAS_LAT(LAT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .we_n        (we_n),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .refresh_cnt (refresh_cnt),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dout_valid) pulses++;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_row(input logic [3:0] r);
        ras_n = 1'b0; addr = r; tick();
    endtask

    task automatic close_row();
        ras_n = 1'b1; tick();
    endtask

    task automatic wr(input logic [3:0] c, input logic [7:0] d);
        cas_n = 1'b0; we_n = 1'b0; addr = c; din = d; tick();
        cas_n = 1'b1; we_n = 1'b1; tick();
    endtask

    task automatic rd(input string tag, input logic [3:0] c, input logic [7:0] exp);
        cas_n = 1'b0; we_n = 1'b1; addr = c; tick();
        cas_n = 1'b1;
        for (int i = 1; i < LAT; i++) begin
            chk({tag, "_early"}, 16'(dout_valid), 16'd0);
            tick();
        end
        chk({tag, "_valid"}, 16'(dout_valid), 16'd1);
        chk({tag, "_data"}, 16'(dout), 16'(exp));
        tick();
        chk({tag, "_pulse_end"}, 16'(dout_valid), 16'd0);
    endtask

    initial begin
        tick(); tick();
        chk("rst_dout", 16'(dout), 16'h0);
        chk("rst_valid", 16'(dout_valid), 16'h0);
        chk("rst_refresh", refresh_cnt, 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        reset_n = 1'b1; tick();

        open_row(4'h3); wr(4'h5, 8'hA5); close_row();
        chk("wr_err", 16'(err), 16'h0);
        chk("wr_pulses", 16'(pulses), 16'd0);

        open_row(4'h3); rd("rd35", 4'h5, 8'hA5); close_row();
        chk("rd35_err", 16'(err), 16'h0);
        chk("rd35_pulses", 16'(pulses), 16'd1);

        open_row(4'h1);
        wr(4'h0, 8'h11); wr(4'h1, 8'h22); wr(4'h2, 8'h33);
        rd("pg2", 4'h2, 8'h33); rd("pg1", 4'h1, 8'h22); rd("pg0", 4'h0, 8'h11);
        close_row();
        chk("pg_pulses", 16'(pulses), 16'd4);

        for (int i = 0; i < 3; i++) begin
            cas_n = 1'b0; tick();
            ras_n = 1'b0; tick();
            ras_n = 1'b1; tick();
            cas_n = 1'b1; tick();
        end
        chk("cbr_count", refresh_cnt, 16'd3);
        chk("cbr_err", 16'(err), 16'h0);
        chk("cbr_pulses", 16'(pulses), 16'd4);
        open_row(4'h3); rd("cbr_rd35", 4'h5, 8'hA5); close_row();

        open_row(4'h3);
        cas_n = 1'b0; we_n = 1'b1; addr = 4'h5; tick();
        ras_n = 1'b1; cas_n = 1'b1; tick();
        chk("abort_valid", 16'(dout_valid), 16'h0);
        chk("abort_err", 16'(err), 16'h1);
        tick(); tick();
        chk("abort_pulses", 16'(pulses), 16'd5);
        open_row(4'h1); rd("sticky_rd", 4'h2, 8'h33); close_row();
        chk("sticky_err", 16'(err), 16'h1);

        open_row(4'h3);
        cas_n = 1'b0; we_n = 1'b1; addr = 4'h5; tick();
        reset_n = 1'b0; #1;
        chk("arst_dout", 16'(dout), 16'h0);
        chk("arst_valid", 16'(dout_valid), 16'h0);
        chk("arst_refresh", refresh_cnt, 16'h0);
        chk("arst_err", 16'(err), 16'h0);
        ras_n = 1'b1; cas_n = 1'b1; tick(); tick(); tick();
        chk("arst_pulses", 16'(pulses), 16'd6);
        reset_n = 1'b1; tick();
        open_row(4'h3); rd("arst_rd35", 4'h5, 8'hA5); close_row();
        chk("arst_rd_err", 16'(err), 16'h0);

        ras_n = 1'b0; cas_n = 1'b0; we_n = 1'b1; addr = 4'h3; tick();
        chk("both_fall_err", 16'(err), 16'h1);
        chk("both_fall_valid", 16'(dout_valid), 16'h0);
        cas_n = 1'b1; tick();
        chk("both_fall_refresh", refresh_cnt, 16'h0);
        rd("both_fall_rd", 4'h5, 8'hA5);
        close_row();
        chk("final_pulses", 16'(pulses), 16'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
